// File: rtl/instr_pkg.sv
// Shared definitions for the fetch/decode/issue sequencer.
// Holds the instruction field bit positions, opcode and condition code constants,
// the sequencer state enum, NZCV flag indices and the condition evaluation helper.
package instr_pkg;

    localparam int NREG = 16;

    // Instruction word layout
    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 24;
    localparam int S_BIT    = 23;
    localparam int SHIFT_HI = 22;
    localparam int SHIFT_LO = 20;
    localparam int RD_HI    = 19;
    localparam int RD_LO    = 16;
    localparam int RS1_HI   = 15;
    localparam int RS1_LO   = 12;
    localparam int RS2_HI   = 11;
    localparam int RS2_LO   = 8;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // Opcodes; 0-7 write a register, 8 compares, 10 stores, 15 halts
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_MOV   = 4'd5;
    localparam logic [3:0] OP_IMMOV = 4'd6;
    localparam logic [3:0] OP_SHF   = 4'd7;
    localparam logic [3:0] OP_CMP   = 4'd8;
    localparam logic [3:0] OP_NOP   = 4'd9;
    localparam logic [3:0] OP_STR   = 4'd10;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Condition codes; 9-15 behave as always
    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_EQ = 4'd1;
    localparam logic [3:0] CC_NE = 4'd2;
    localparam logic [3:0] CC_CS = 4'd3;
    localparam logic [3:0] CC_CC = 4'd4;
    localparam logic [3:0] CC_MI = 4'd5;
    localparam logic [3:0] CC_PL = 4'd6;
    localparam logic [3:0] CC_VS = 4'd7;
    localparam logic [3:0] CC_VC = 4'd8;

    // Flag positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // True when the instruction's condition holds against the given flags
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic pass;
        case (cond)
            CC_EQ:   pass = flags[FLAG_Z];
            CC_NE:   pass = !flags[FLAG_Z];
            CC_CS:   pass = flags[FLAG_C];
            CC_CC:   pass = !flags[FLAG_C];
            CC_MI:   pass = flags[FLAG_N];
            CC_PL:   pass = !flags[FLAG_N];
            CC_VS:   pass = flags[FLAG_V];
            CC_VC:   pass = !flags[FLAG_V];
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/issue_regfile.sv
// 16x32 register file for the issue sequencer.
// Two asynchronous read ports, one synchronous write port, synchronous active-high
// reset clearing every register to zero.
//   clk, reset        : clock and synchronous reset
//   we, waddr, wdata  : write strobe, register index and data
//   raddr1/2, rdata1/2: combinational read ports
module issue_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr1,
    input  logic [3:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    import instr_pkg::*;

    logic [31:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/instr_issue_ctrl.sv
// Multi-cycle fetch/decode/issue sequencer feeding the ALU control block.
// Sequence per instruction: FETCH (req/valid handshake) -> DECODE (read sources)
// -> EXEC (ALU works on held fields, result sampled) -> WB (commit, advance PC).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start                      : leave IDLE and begin fetching
//   pc_in, pc_trigger, pc_reset: external program counter value and controls
//   imem_req/addr/valid/data   : instruction fetch handshake
//   condition, opcode, s, shift, immediate_value, source1, source2 : ALU fields
//   alu_result, alu_flags      : ALU outputs sampled at the end of EXEC
//   dmem_we/addr/wdata         : store strobe, address and data
//   flags_q                    : architectural NZCV register
//   halted                     : high while halted
module instr_issue_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] pc_in,
    output logic          pc_trigger,
    output logic          pc_reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [31:0]   imem_data,
    output logic [3:0]    condition,
    output logic [3:0]    opcode,
    output logic          s,
    output logic [2:0]    shift,
    output logic [15:0]   immediate_value,
    output logic [31:0]   source1,
    output logic [31:0]   source2,
    input  logic [31:0]   alu_result,
    input  logic [3:0]    alu_flags,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    flags_q,
    output logic          halted
);
    import instr_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  rflags_q, rflags_d;
    logic [3:0]  flags_d;
    logic        pc_trigger_q, pc_trigger_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        halted_q, halted_d;

    logic        rf_we;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [3:0]  op;
    logic        exec_ok;

    assign op = instr_q[OP_HI:OP_LO];

    // Compare always executes; everything else is gated by its condition against the
    // flags as they stand before this instruction commits.
    assign exec_ok = (op == OP_CMP) || cond_pass(instr_q[COND_HI:COND_LO], flags_q);

    issue_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (instr_q[RD_HI:RD_LO]),
        .wdata  (res_q),
        .raddr1 (instr_q[RS1_HI:RS1_LO]),
        .raddr2 (instr_q[RS2_HI:RS2_LO]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Next-state and commit logic. Strobes are registered from the next state so they
    // line up exactly with the state they belong to.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        res_d    = res_q;
        rflags_d = rflags_q;
        flags_d  = flags_q;
        rf_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                src1_d  = rf_rdata1;
                src2_d  = rf_rdata2;
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                res_d    = alu_result;
                rflags_d = alu_flags;
                state_d  = ST_WB;
            end
            ST_WB: begin
                state_d = ST_FETCH;
                if (exec_ok) begin
                    rf_we = !op[3];
                    if (instr_q[S_BIT] || (op == OP_CMP)) begin
                        flags_d = rflags_q;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d   = (state_d == ST_FETCH);
        pc_trigger_d = (state_d == ST_WB);
        dmem_we_d    = (state_d == ST_WB) && exec_ok && (op == OP_STR);
        halted_d     = (state_d == ST_HALT);
    end

    // State and output registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            res_q        <= '0;
            rflags_q     <= '0;
            flags_q      <= '0;
            pc_trigger_q <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            res_q        <= res_d;
            rflags_q     <= rflags_d;
            flags_q      <= flags_d;
            pc_trigger_q <= pc_trigger_d;
            imem_req_q   <= imem_req_d;
            dmem_we_q    <= dmem_we_d;
            halted_q     <= halted_d;
        end
    end

    // pc_reset is decoded combinationally so the counter clears on the same edge that
    // enters FETCH, making the very first fetch address already the cleared PC.
    assign pc_reset        = (state_q == ST_IDLE) && start;
    assign pc_trigger      = pc_trigger_q;
    assign imem_req        = imem_req_q;
    assign imem_addr       = imem_req_q ? pc_in : '0;
    assign dmem_we         = dmem_we_q;
    assign halted          = halted_q;

    assign condition       = instr_q[COND_HI:COND_LO];
    assign opcode          = op;
    assign s               = instr_q[S_BIT];
    assign shift           = instr_q[SHIFT_HI:SHIFT_LO];
    assign immediate_value = instr_q[IMM_HI:IMM_LO];
    assign source1         = src1_q;
    assign source2         = src2_q;
    assign dmem_addr       = src1_q[AW-1:0];
    assign dmem_wdata      = res_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl.
// Runs a short program through the sequencer acting as instruction memory, ALU and
// program counter; expected write-back observations are queued at fetch and checked
// when the sequencer pulses pc_trigger.
module tb_instr_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pc_in = 8'h33;
    logic        pc_trigger, pc_reset, imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [3:0]  condition, opcode;
    logic        s;
    logic [2:0]  shift;
    logic [15:0] immediate_value;
    logic [31:0] source1, source2;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  flags_q;
    logic        halted;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit first_pending = 1'b0;
    bit flag_pending = 1'b0;
    logic [3:0] flag_exp;
    logic [7:0] exp_pc;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] res;
        logic        we;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Program: instruction, ALU result/flags to return, expected sources, store, flags after
    logic [31:0] prog_instr [0:10] = '{32'h06010005, 32'h00821100, 32'h08001100, 32'h20831100,
                                       32'h00052300, 32'h06040012, 32'h0A044000, 32'h00064000,
                                       32'h10D55500, 32'h0F000000, 32'h1E8FFFFF};
    logic [31:0] prog_res   [0:10] = '{32'h5, 32'hA, 32'h0, 32'h77, 32'h55, 32'h12, 32'hDEADBEEF,
                                       32'h1, 32'hAA, 32'h0, 32'h1234};
    logic [3:0]  prog_fin   [0:10] = '{4'b0000, 4'b0000, 4'b0100, 4'b1010, 4'b0000, 4'b0000,
                                       4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
    logic [31:0] prog_src1  [0:10] = '{32'h0, 32'h5, 32'h5, 32'h5, 32'hA, 32'h0, 32'h12, 32'h12,
                                       32'h55, 32'h0, 32'h0};
    logic [31:0] prog_src2  [0:10] = '{32'h0, 32'h5, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h55, 32'h0, 32'h0};
    logic        prog_we    [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b0, 1'b0};
    logic [3:0]  prog_fout  [0:10] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                       4'b0100, 4'b0100, 4'b1001, 4'b0000, 4'b0000};

    instr_issue_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pc_in           (pc_in),
        .pc_trigger      (pc_trigger),
        .pc_reset        (pc_reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_data       (imem_data),
        .condition       (condition),
        .opcode          (opcode),
        .s               (s),
        .shift           (shift),
        .immediate_value (immediate_value),
        .source1         (source1),
        .source2         (source2),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .flags_q         (flags_q),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // External program counter driven by the sequencer's pc_reset/pc_trigger
    always @(posedge clk) begin
        if (pc_reset) pc_in <= 8'h00;
        else if (pc_trigger) pc_in <= pc_in + 8'h01;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_strobes"}, {27'd0, pc_trigger, pc_reset, imem_req, dmem_we, halted}, 32'd0);
        checkOutput({tag, "_fields"}, {4'd0, condition, opcode, s, shift, immediate_value}, 32'd0);
        checkOutput({tag, "_source1"}, source1, 32'd0);
        checkOutput({tag, "_source2"}, source2, 32'd0);
        checkOutput({tag, "_addrs_flags"}, {12'd0, dmem_addr, imem_addr, flags_q}, 32'd0);
        checkOutput({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    endtask

    // Wait for a fetch, optionally stall it, then return program entry idx
    task automatic applyStimulus(input int idx, input int delay, input bit push);
        int waited;
        exp_t e;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (imem_req !== 1'b1) begin
            checkOutput("imem_req_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        for (int d = 0; d < delay; d++) begin
            checkOutput("stall_imem_req", {31'd0, imem_req}, 32'd1);
            checkOutput("stall_imem_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
            checkOutput("stall_no_trigger", {31'd0, pc_trigger}, 32'd0);
            @(negedge clk);
        end
        checkOutput("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
        imem_valid = 1'b1;
        imem_data  = prog_instr[idx];
        alu_result = prog_res[idx];
        alu_flags  = prog_fin[idx];
        if (push) begin
            e.instr = prog_instr[idx];
            e.src1  = prog_src1[idx];
            e.src2  = prog_src2[idx];
            e.res   = prog_res[idx];
            e.we    = prog_we[idx];
            e.flags = prog_fout[idx];
            sb_q.push_back(e);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'hFFFF_FFFF;
        exp_pc     = exp_pc + 8'h01;
    endtask

    // Write-back monitor: pops one expectation per pc_trigger pulse
    always @(negedge clk) begin
        if (flag_pending) begin
            checkOutput("flags_q", {28'd0, flags_q}, {28'd0, flag_exp});
            checkOutput("dmem_we_pulse", {31'd0, dmem_we}, 32'd0);
            flag_pending = 1'b0;
        end
        if (!reset && pc_trigger === 1'b1) begin
            checkOutput("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("wb_condition", {28'd0, condition}, {28'd0, mon_e.instr[31:28]});
                checkOutput("wb_opcode", {28'd0, opcode}, {28'd0, mon_e.instr[27:24]});
                checkOutput("wb_s_shift", {28'd0, s, shift}, {28'd0, mon_e.instr[23:20]});
                checkOutput("wb_immediate", {16'd0, immediate_value}, {16'd0, mon_e.instr[15:0]});
                checkOutput("wb_source1", source1, mon_e.src1);
                checkOutput("wb_source2", source2, mon_e.src2);
                checkOutput("wb_dmem_we", {31'd0, dmem_we}, {31'd0, mon_e.we});
                checkOutput("wb_dmem_addr", {24'd0, dmem_addr}, {24'd0, mon_e.src1[7:0]});
                checkOutput("wb_dmem_wdata", dmem_wdata, mon_e.res);
                flag_exp     = mon_e.flags;
                flag_pending = 1'b1;
            end
            if (first_pending) begin
                checkOutput("first_trigger_cycle", cyc - start_cyc, 32'd4);
                first_pending = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        alu_result = 32'h0;
        alu_flags  = 4'h0;
        exp_pc     = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Start pulse clears the PC, then the program runs to the halt
        start = 1'b1;
        #1;
        checkOutput("pc_reset_on_start", {31'd0, pc_reset}, 32'd1);
        start_cyc     = cyc;
        first_pending = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i, (i == 7) ? 3 : 0, i != 9);
        end

        // Halt: stays put, no fetches, no PC advance
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("halted", {31'd0, halted}, 32'd1);
            checkOutput("halt_no_req", {31'd0, imem_req, pc_trigger}, 32'd0);
            @(negedge clk);
        end
        checkOutput("sb_drained", sb_q.size(), 32'd0);

        // Reset out of halt, restart, and abandon an instruction in EXEC
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("halt_cleared", {31'd0, halted}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_pc = 8'h00;
        applyStimulus(10, 0, 1'b0);
        @(negedge clk);
        checkOutput("exec_opcode", {28'd0, opcode}, 32'hE);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkAllZero("reset_in_exec");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_after_reset", {30'd0, pc_trigger, imem_req}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
